shift_seq_ctrl: RTL and testbench

- Command sequencer directly upstream of the 4-bit shift register; generates its d_in, ld, sr, sl and s_cnt controls.
- Accepts shift/load commands over a valid/ready handshake and buffers them in a small FIFO.
- Replays each command for a programmable number of cycles, then signals completion.

---
 rtl/shift_seq_pkg.sv | 43 ++++
 rtl/shift_seq_fifo.sv | 50 +++++
 rtl/shift_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types for the shift-register command sequencer.
// Commands carry op, shift amount, load data and repeat count.
package shift_seq_pkg;

  localparam int DATA_W    = 4;
  localparam int AMT_W     = 2;
  localparam int REP_MAX_W = 8;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_SHR  = 2'b10,
    OP_SHL  = 2'b11
  } op_e;

  typedef struct packed {
    op_e                  op;
    logic [AMT_W-1:0]     amt;
    logic [DATA_W-1:0]    data;
    logic [REP_MAX_W-1:0] rep;
  } cmd_t;

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_e;

  function automatic logic [DATA_W-1:0] shadow_next(
    input logic [DATA_W-1:0] cur,
    input logic              ld,
    input logic              sr,
    input logic [DATA_W-1:0] data,
    input logic [AMT_W-1:0]  amt
  );
    if (ld)
      return data;
    else if (sr)
      return cur >> amt;
    else
      return cur << amt;
  endfunction

endpackage

// File: rtl/shift_seq_fifo.sv
// Command FIFO for shift_seq_ctrl; DEPTH must be a power of two.
// Pointers carry one extra wrap bit to tell full from empty.
module shift_seq_fifo
  import shift_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  cmd_t wdata,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  cmd_t        mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push)
        wptr <= wptr + (AW+1)'(1);
      if (pop)
        rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer driving the 4-bit shift register controls.
// Define SHIFT_SEQ_SHADOW_EN to build the exp_q shadow register.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int REP_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [AMT_W-1:0]  cmd_amt,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [REP_W-1:0]  cmd_rep,
  input  logic              halt,
  input  logic              flush,
  output logic [DATA_W-1:0] d_out,
  output logic              ld,
  output logic              sr,
  output logic              sl,
  output logic [AMT_W-1:0]  s_cnt,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] exp_q
);

  state_e             state_q, state_d;
  cmd_t               cur_q, cur_d;
  logic [REP_W-1:0]   cnt_q, cnt_d;
  logic               act_q, act_d;
  logic               ready_en_q;
  logic               pop, push, full, empty, last;
  cmd_t               head, wcmd;

  logic               ld_d, sr_d, sl_d, done_d;
  logic [DATA_W-1:0]  d_d;
  logic [AMT_W-1:0]   s_d;

  assign cmd_ready = ready_en_q && !full;
  assign push      = cmd_valid && cmd_ready && !flush;
  assign busy      = (state_q == S_ISSUE) || !empty;
  assign last      = act_q && (REP_MAX_W'(cnt_q) == cur_q.rep);

  assign wcmd = '{op:   op_e'(cmd_op),
                  amt:  cmd_amt,
                  data: cmd_data,
                  rep:  REP_MAX_W'(cmd_rep)};

  shift_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wcmd),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      cnt_q      <= '0;
      act_q      <= 1'b0;
      ready_en_q <= 1'b0;
      ld         <= 1'b0;
      sr         <= 1'b0;
      sl         <= 1'b0;
      done       <= 1'b0;
      d_out      <= '0;
      s_cnt      <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      act_q      <= act_d;
      ready_en_q <= 1'b1;
      ld         <= ld_d;
      sr         <= sr_d;
      sl         <= sl_d;
      done       <= done_d;
      d_out      <= d_d;
      s_cnt      <= s_d;
    end
  end

  // act marks a real issue cycle; halted cycles in ISSUE are bubbles
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      act_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!empty && !halt) begin
            pop     = 1'b1;
            cur_d   = head;
            cnt_d   = '0;
            act_d   = 1'b1;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (last) begin
            if (!empty && !halt) begin
              pop   = 1'b1;
              cur_d = head;
              cnt_d = '0;
              act_d = 1'b1;
            end else begin
              state_d = S_IDLE;
              cnt_d   = '0;
              act_d   = 1'b0;
            end
          end else begin
            if (act_q)
              cnt_d = cnt_q + REP_W'(1);
            act_d = !halt;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ld_d   = 1'b0;
    sr_d   = 1'b0;
    sl_d   = 1'b0;
    done_d = 1'b0;
    d_d    = '0;
    s_d    = '0;
    if (state_d == S_ISSUE) begin
      d_d = cur_d.data;
      s_d = cur_d.amt;
      if (act_d) begin
        unique case (1'b1)
          cur_d.op == OP_LOAD: ld_d = 1'b1;
          cur_d.op == OP_SHR:  sr_d = 1'b1;
          cur_d.op == OP_SHL:  sl_d = 1'b1;
          default: ;
        endcase
        done_d = (REP_MAX_W'(cnt_d) == cur_d.rep);
      end
    end
  end

`ifdef SHIFT_SEQ_SHADOW_EN
  logic [DATA_W-1:0] shadow_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      shadow_q <= '0;
    else if (ld || sr || sl)
      shadow_q <= shadow_next(shadow_q, ld, sr, d_out, s_cnt);
  end

  assign exp_q = shadow_q;
`else
  assign exp_q = '0;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed vector tables, reset corner,
// and random traffic against a queue-based reference model.
module tb_shift_seq_ctrl;

  localparam int DEPTH = 4;
  localparam int REP_W = 3;
`ifdef SHIFT_SEQ_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  localparam logic [1:0] N = 2'd0;
  localparam logic [1:0] L = 2'd1;
  localparam logic [1:0] R = 2'd2;
  localparam logic [1:0] S = 2'd3;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready;
  logic [1:0] cmd_op, cmd_amt;
  logic [3:0] cmd_data;
  logic [REP_W-1:0] cmd_rep;
  logic halt, flush;
  logic [3:0] d_out, exp_q;
  logic ld, sr, sl, busy, done;
  logic [1:0] s_cnt;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.DEPTH(DEPTH), .REP_W(REP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .cmd_data  (cmd_data),
    .cmd_rep   (cmd_rep),
    .halt      (halt),
    .flush     (flush),
    .d_out     (d_out),
    .ld        (ld),
    .sr        (sr),
    .sl        (sl),
    .s_cnt     (s_cnt),
    .busy      (busy),
    .done      (done),
    .exp_q     (exp_q)
  );

  int n_chk = 0;
  int n_pass = 0;

  function automatic logic [15:0] mk(
    logic e_ld, logic e_sr, logic e_sl,
    logic [3:0] e_d, logic [1:0] e_s,
    logic e_dn, logic e_bz, logic e_rdy,
    logic [3:0] e_x
  );
    return {e_ld, e_sr, e_sl, e_d, e_s,
            e_dn, e_bz, e_rdy, SH ? e_x : 4'h0};
  endfunction

  function automatic logic [15:0] dut_v();
    return {ld, sr, sl, d_out, s_cnt,
            done, busy, cmd_ready, exp_q};
  endfunction

  task automatic check(string nm, logic [15:0] got,
                       logic [15:0] want);
    n_chk++;
    if (got === want)
      n_pass++;
    else
      $display("FAIL %s: got %h want %h", nm, got, want);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic        v;
    logic [1:0]  op;
    logic [1:0]  amt;
    logic [3:0]  data;
    logic [2:0]  rep;
    logic        h;
    logic        f;
    logic [15:0] exp;
  } row_t;

  row_t rows[$];

  task automatic add(
    string nm, logic v, logic [1:0] op, logic [1:0] amt,
    logic [3:0] data, logic [2:0] rep, logic h, logic f,
    logic e_ld, logic e_sr, logic e_sl,
    logic [3:0] e_d, logic [1:0] e_s,
    logic e_dn, logic e_bz, logic e_rdy, logic [3:0] e_x
  );
    row_t r;
    r.name = nm; r.v = v; r.op = op; r.amt = amt;
    r.data = data; r.rep = rep; r.h = h; r.f = f;
    r.exp = mk(e_ld, e_sr, e_sl, e_d, e_s,
               e_dn, e_bz, e_rdy, e_x);
    rows.push_back(r);
  endtask

  task automatic drive(logic v, logic [1:0] op,
                       logic [1:0] amt, logic [3:0] data,
                       logic [2:0] rep, logic h, logic f);
    cmd_valid = v; cmd_op = op; cmd_amt = amt;
    cmd_data = data; cmd_rep = rep; halt = h; flush = f;
  endtask

  task automatic fill_rows();
    // single LOAD
    add("ld1_push", 1,L,0,4'hA,0,0,0, 0,0,0,4'h0,0,0,1,1,4'h0);
    add("ld1_iss",  0,N,0,4'h0,0,0,0, 1,0,0,4'hA,0,1,1,1,4'h0);
    add("ld1_end",  0,N,0,4'h0,0,0,0, 0,0,0,4'h0,0,0,0,1,4'hA);
    // back-to-back LOAD then SHR x3
    add("b2b_0", 1,L,0,4'hF,0,0,0, 0,0,0,4'h0,0,0,1,1,4'hA);
    add("b2b_1", 1,R,1,4'h0,2,0,0, 1,0,0,4'hF,0,1,1,1,4'hA);
    add("b2b_2", 0,N,0,4'h0,0,0,0, 0,1,0,4'h0,1,0,1,1,4'hF);
    add("b2b_3", 0,N,0,4'h0,0,0,0, 0,1,0,4'h0,1,0,1,1,4'h7);
    add("b2b_4", 0,N,0,4'h0,0,0,0, 0,1,0,4'h0,1,1,1,1,4'h3);
    add("b2b_5", 0,N,0,4'h0,0,0,0, 0,0,0,4'h0,0,0,0,1,4'h1);
    // halt during SHL amt2 rep1
    add("hlt_0", 1,L,0,4'h1,0,0,0, 0,0,0,4'h0,0,0,1,1,4'h1);
    add("hlt_1", 1,S,2,4'h0,1,0,0, 1,0,0,4'h1,0,1,1,1,4'h1);
    add("hlt_2", 0,N,0,4'h0,0,0,0, 0,0,1,4'h0,2,0,1,1,4'h1);
    add("hlt_3", 0,N,0,4'h0,0,1,0, 0,0,0,4'h0,2,0,1,1,4'h4);
    add("hlt_4", 0,N,0,4'h0,0,1,0, 0,0,0,4'h0,2,0,1,1,4'h4);
    add("hlt_5", 0,N,0,4'h0,0,0,0, 0,0,1,4'h0,2,1,1,1,4'h4);
    add("hlt_6", 0,N,0,4'h0,0,0,0, 0,0,0,4'h0,0,0,0,1,4'h0);
    // fill FIFO under halt, 5th held off
    add("fil_0", 1,L,0,4'h1,0,1,0, 0,0,0,4'h0,0,0,1,1,4'h0);
    add("fil_1", 1,L,0,4'h2,0,1,0, 0,0,0,4'h0,0,0,1,1,4'h0);
    add("fil_2", 1,L,0,4'h3,0,1,0, 0,0,0,4'h0,0,0,1,1,4'h0);
    add("fil_3", 1,L,0,4'h4,0,1,0, 0,0,0,4'h0,0,0,1,0,4'h0);
    add("fil_4", 1,L,0,4'h5,0,1,0, 0,0,0,4'h0,0,0,1,0,4'h0);
    add("fil_5", 1,L,0,4'h5,0,0,0, 1,0,0,4'h1,0,1,1,1,4'h0);
    add("fil_6", 1,L,0,4'h5,0,0,0, 1,0,0,4'h2,0,1,1,1,4'h1);
    add("fil_7", 0,N,0,4'h0,0,0,0, 1,0,0,4'h3,0,1,1,1,4'h2);
    add("fil_8", 0,N,0,4'h0,0,0,0, 1,0,0,4'h4,0,1,1,1,4'h3);
    add("fil_9", 0,N,0,4'h0,0,0,0, 1,0,0,4'h5,0,1,1,1,4'h4);
    add("fil_a", 0,N,0,4'h0,0,0,0, 0,0,0,4'h0,0,0,0,1,4'h5);
    // flush with one issuing and three queued
    add("fls_0", 1,S,1,4'h0,3,0,0, 0,0,0,4'h0,0,0,1,1,4'h5);
    add("fls_1", 1,L,0,4'h9,0,0,0, 0,0,1,4'h0,1,0,1,1,4'h5);
    add("fls_2", 1,S,1,4'h0,0,0,0, 0,0,1,4'h0,1,0,1,1,4'hA);
    add("fls_3", 1,N,0,4'h0,0,0,0, 0,0,1,4'h0,1,0,1,1,4'h4);
    add("fls_4", 1,L,0,4'hF,0,1,1, 0,0,0,4'h0,0,0,0,1,4'h8);
    add("fls_5", 0,N,0,4'h0,0,0,0, 0,0,0,4'h0,0,0,0,1,4'h8);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0] op;
    logic [1:0] amt;
    logic [3:0] data;
    int         rep;
  } mcmd_t;

  mcmd_t      mq[$];
  mcmd_t      mcur;
  bit         mcur_v, mshow, mready_en;
  int         mleft;
  logic [3:0] mexp;

  task automatic m_reset();
    mq.delete();
    mcur_v = 0; mshow = 0; mready_en = 0;
    mleft = 0; mexp = 4'h0;
    mcur = '{2'd0, 2'd0, 4'd0, 0};
  endtask

  function automatic logic [15:0] m_out();
    logic o_ld, o_sr, o_sl;
    o_ld = mshow && (mcur.op == L);
    o_sr = mshow && (mcur.op == R);
    o_sl = mshow && (mcur.op == S);
    return mk(o_ld, o_sr, o_sl,
              mcur_v ? mcur.data : 4'h0,
              mcur_v ? mcur.amt : 2'h0,
              mshow && (mleft == 1),
              mcur_v || (mq.size() != 0),
              mready_en && (mq.size() < DEPTH),
              mexp);
  endfunction

  task automatic m_edge();
    bit acc;
    acc = cmd_valid && mready_en && (mq.size() < DEPTH);
    if (mshow) begin
      case (mcur.op)
        L: mexp = mcur.data;
        R: mexp = mexp >> mcur.amt;
        S: mexp = mexp << mcur.amt;
        default: ;
      endcase
    end
    if (flush) begin
      mq.delete();
      mcur_v = 0;
      mshow = 0;
    end else begin
      if (mshow) mleft--;
      if (mcur_v && mleft == 0) mcur_v = 0;
      if (!mcur_v) begin
        if (mq.size() > 0 && !halt) begin
          mcur = mq.pop_front();
          mleft = mcur.rep + 1;
          mcur_v = 1;
          mshow = 1;
        end else begin
          mshow = 0;
        end
      end else begin
        mshow = !halt;
      end
      if (acc)
        mq.push_back('{cmd_op, cmd_amt, cmd_data, int'(cmd_rep)});
    end
    mready_en = 1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0;
    drive(0, N, 0, 4'h0, 0, 0, 0);
    #7;
    check("reset_state", dut_v(), 16'h0000);
    #5 rst = 1'b1;
    #1 check("rdy_pre_edge", dut_v(), 16'h0000);
    @(posedge clk); #1;
    check("rdy_post_edge", dut_v(),
          mk(0,0,0,4'h0,0,0,0,1,4'h0));

    fill_rows();
    foreach (rows[i]) begin
      drive(rows[i].v, rows[i].op, rows[i].amt,
            rows[i].data, rows[i].rep, rows[i].h, rows[i].f);
      @(posedge clk); #1;
      check($sformatf("%s[%0d]", rows[i].name, i),
            dut_v(), rows[i].exp);
    end
    drive(0, N, 0, 4'h0, 0, 0, 0);

    // reset during the 2nd issue cycle of a rep=3 SHR
    drive(1, R, 1, 4'h3, 3, 0, 0);
    @(posedge clk); #1;
    drive(0, N, 0, 4'h0, 0, 0, 0);
    @(posedge clk); #1;
    check("rmid_iss1", dut_v(),
          mk(0,1,0,4'h3,1,0,1,1,SH ? 4'h8 : 4'h0));
    @(posedge clk); #2;
    rst = 1'b0;
    #1 check("rmid_async", dut_v(), 16'h0000);
    #4 rst = 1'b1;
    #1 check("rmid_hold", dut_v(), 16'h0000);
    @(posedge clk); #1;
    check("rmid_ready", dut_v(),
          mk(0,0,0,4'h0,0,0,0,1,4'h0));

    // random traffic against the model
    m_reset();
    mready_en = 1;
    check("rnd_start", dut_v(), m_out());
    for (int c = 0; c < 3000; c++) begin
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_amt   = 2'($urandom_range(0, 3));
      cmd_data  = 4'($urandom_range(0, 15));
      cmd_rep   = REP_W'($urandom_range(0, 7));
      halt      = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      m_edge();
      #1;
      check($sformatf("rnd[%0d]", c), dut_v(), m_out());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
